// File: rtl/coef_bank_ctrl.sv
// Coefficient bank controller for an NTAP-tap FIR filter.
// A new coefficient set is streamed into a shadow bank over a valid/ready
// handshake. It is then copied into the active bank in a single edge at the
// next sample boundary, so the filter never sees a half-updated bank.
module coef_bank_ctrl #(
  parameter int              NTAP  = 16,
  parameter int              CW    = 16,
  parameter logic [CW-1:0]   UNITY = 16'h7FFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CW-1:0]              cfg_data,
  input  logic                       sample_en,
  output logic [NTAP-1:0][CW-1:0]    coef,
  output logic                       busy,
  output logic                       swap_done,
  output logic                       cfg_err
);

  localparam int              IW       = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NTAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic                    r_cfg_ready;
  logic                    r_busy;
  logic                    r_swap_done;
  logic                    r_cfg_err;
  logic [NTAP-1:0][CW-1:0] r_shadow;
  logic [NTAP-1:0][CW-1:0] r_coef;

  logic                    w_hs;
  logic                    w_wr_en;
  logic                    w_swap;

  // A restart in LOAD takes priority: the word offered in that cycle is discarded.
  assign w_hs    = cfg_valid & r_cfg_ready;
  assign w_wr_en = (r_state == S_LOAD) & w_hs & ~cfg_start;
  assign w_swap  = (r_state == S_ARMED) & sample_en;

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign swap_done = r_swap_done;
  assign cfg_err   = r_cfg_err;
  assign coef      = r_coef;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_swap_done <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_swap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_cfg_err   <= 1'b0;
          end
          // A stray word is always an error, even alongside a start.
          if (cfg_valid) begin
            r_cfg_err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_start) begin
            r_idx <= '0;
          end else if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= S_ARMED;
              r_cfg_ready <= 1'b0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_ARMED: begin
          if (cfg_start || cfg_valid) begin
            r_cfg_err <= 1'b1;
          end
          if (sample_en) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_swap_done <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Shadow bank: written one word per accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the banks are small register arrays, not RAM macros, and they
      // need defined contents from reset, so resetting them costs nothing in
      // memory inference and guarantees a known bank after power-up.
      r_shadow <= '0;
    end else if (w_wr_en) begin
      r_shadow[r_idx] <= cfg_data;
    end
  end

  // Active bank: all taps replaced together on the armed sample boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef    <= '0;
      r_coef[0] <= UNITY;
    end else if (w_swap) begin
      r_coef <= r_shadow;
    end
  end

endmodule

// File: tb/tb_coef_bank_ctrl.sv
// Directed self-checking bench for coef_bank_ctrl. Every expected active
// bank is pushed to a scoreboard when the swapping sample_en is driven and
// popped when swap_done is seen.
module tb_coef_bank_ctrl;

  localparam int NTAP = 16;
  localparam int CW   = 16;
  localparam int BW   = NTAP * CW;

  logic                    clk;
  logic                    rst_n;
  logic                    cfg_start;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CW-1:0]           cfg_data;
  logic                    sample_en;
  logic [NTAP-1:0][CW-1:0] coef;
  logic                    busy;
  logic                    swap_done;
  logic                    cfg_err;

  coef_bank_ctrl #(
    .NTAP  (NTAP),
    .CW    (CW),
    .UNITY (16'h7FFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .sample_en (sample_en),
    .coef      (coef),
    .busy      (busy),
    .swap_done (swap_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model.
  logic [NTAP-1:0][CW-1:0] m_shadow;
  logic [NTAP-1:0][CW-1:0] m_active;
  logic [NTAP-1:0][CW-1:0] m_reset_bank;
  int                      m_idx;
  int                      m_state;   // 0 idle, 1 load, 2 armed
  logic                    m_err;
  logic [BW-1:0]           sb_q[$];

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each swap_done pulse must match the oldest pushed bank.
  always @(negedge clk) begin
    if (rst_n && swap_done) begin
      check("swap_expected", BW'(sb_q.size() != 0), BW'(1));
      if (sb_q.size() != 0) begin
        check("swap_coef", coef, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"},  BW'(busy),      BW'(m_state != 0));
    check({tag, "_ready"}, BW'(cfg_ready), BW'(m_state == 1));
    check({tag, "_err"},   BW'(cfg_err),   BW'(m_err));
    check({tag, "_coef"},  coef,           m_active);
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_active = m_reset_bank;
    m_idx    = 0;
    m_state  = 0;
    m_err    = 1'b0;
  endtask

  task automatic do_start(input logic with_valid = 1'b0);
    cfg_start = 1'b1;
    cfg_valid = with_valid;
    cfg_data  = 16'h1234;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    if (m_state == 2) begin
      m_err = 1'b1;
    end else begin
      if (m_state == 0) m_err = with_valid;
      m_state = 1;
      m_idx   = 0;
    end
  endtask

  // One accepted word in LOAD, optionally with a coincident sample_en.
  task automatic send(input logic [CW-1:0] d, input logic with_sample = 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = d;
    sample_en = with_sample;
    tick();
    cfg_valid = 1'b0;
    sample_en = 1'b0;
    m_shadow[m_idx] = d;
    if (m_idx == NTAP - 1) m_state = 2;
    else                   m_idx++;
  endtask

  // Stray word outside LOAD: dropped, flags an error.
  task automatic stray_valid();
    cfg_valid = 1'b1;
    cfg_data  = 16'hDEAD;
    tick();
    cfg_valid = 1'b0;
    m_err = 1'b1;
  endtask

  // Sample strobe; a swap is expected only when the model is armed.
  task automatic strobe(input string tag);
    logic exp_swap;
    exp_swap  = (m_state == 2);
    sample_en = 1'b1;
    if (exp_swap) begin
      sb_q.push_back(m_shadow);
      m_active = m_shadow;
      m_state  = 0;
    end
    tick();
    sample_en = 1'b0;
    check({tag, "_swap_done"}, BW'(swap_done), BW'(exp_swap));
    check_status(tag);
    tick();
    check({tag, "_swap_done_1cyc"}, BW'(swap_done), BW'(0));
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_swap_done"}, BW'(swap_done), BW'(0));
    check_status(tag);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    m_reset_bank    = '0;
    m_reset_bank[0] = 16'h7FFF;
    model_reset();
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    sample_en = 1'b0;
    repeat (3) tick();
    check("rst_swap_done", BW'(swap_done), BW'(0));
    check_status("rst");
    rst_n = 1'b1;
    tick();

    // sample_en in IDLE leaves the bank alone.
    strobe("idle_strobe");

    // Basic load 1..16 with gaps, sample_en during LOAD ignored, then swap.
    do_start();
    check_status("load_begin");
    for (int i = 0; i < NTAP; i++) begin
      send(CW'(i + 1));
      if (i % 4 == 1) tick();
      if (i == 5) begin
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("load_strobe_coef", coef, m_active);
      end
    end
    check_status("armed");
    tick();
    check("armed_hold_coef", coef, m_active);
    strobe("swap1");

    // Sign extremes pass bit-exact.
    do_start();
    for (int i = 0; i < NTAP; i++) begin
      if (i == 3)       send(16'h8000);
      else if (i == 15) send(16'hFFFF);
      else              send(CW'(i * 3 + 100));
    end
    strobe("swap_sign");
    check("tap3",  BW'(coef[3]),  BW'(16'h8000));
    check("tap15", BW'(coef[15]), BW'(16'hFFFF));

    // Final handshake coincides with sample_en: no swap until the next strobe.
    do_start();
    for (int i = 0; i < NTAP - 1; i++) send(CW'(16'h0A00 + i));
    send(16'h0AFF, 1'b1);
    check("coincide_swap_done", BW'(swap_done), BW'(0));
    check_status("coincide");
    tick();
    check("coincide_late_swap_done", BW'(swap_done), BW'(0));
    strobe("swap_late");

    // Restart after 7 words (the word offered with the restart is discarded).
    do_start();
    for (int i = 0; i < 7; i++) send(CW'(16'h0C00 + i));
    do_start(1'b1);
    check_status("restart");
    for (int i = 0; i < NTAP; i++) send(16'h0055);
    strobe("swap_restart");

    // Protocol errors: start in ARMED, then a stray word in IDLE.
    do_start();
    for (int i = 0; i < NTAP; i++) send(CW'(16'h1100 + i));
    do_start();
    check_status("armed_start");
    strobe("swap_err");
    stray_valid();
    check_status("idle_valid");
    do_start();
    check_status("err_cleared");

    // Reset in the middle of a load restores the reset bank; no swap follows.
    for (int i = 0; i < 10; i++) send(CW'(16'h2200 + i));
    apply_reset("mid_load_rst");
    strobe("post_rst_strobe");

    repeat (3) tick();
    check("scoreboard_drained", BW'(sb_q.size()), BW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/coef_bank_ctrl.md
COEF_BANK_CTRL -- requirements
Module: coef_bank_ctrl

Interface
REQ-001 Parameter NTAP, default 16, number of filter taps (coefficient words).
REQ-002 Parameter CW, default 16, coefficient width in bits, two's complement.
REQ-003 Parameter UNITY, default 16'h7FFF, reset value of active coefficient 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 cfg_start  input  1  request to begin a new coefficient load.
REQ-007 cfg_valid  input  1  cfg_data holds a coefficient word.
REQ-008 cfg_ready  output  1  controller accepts a word this cycle.
REQ-009 cfg_data  input  CW  signed coefficient word.
REQ-010 sample_en  input  1  sample-boundary strobe, one cycle per filter input sample.
REQ-011 coef  output  NTAP x CW  active coefficient bank, coef[0] is the tap on the undelayed input.
REQ-012 busy  output  1  high in LOAD or ARMED.
REQ-013 swap_done  output  1  one-cycle pulse, new bank visible on coef.
REQ-014 cfg_err  output  1  sticky protocol-error flag.

Function
REQ-015 FSM states: IDLE, LOAD, ARMED; the reset state is IDLE.
REQ-016 IDLE: cfg_ready=0; cfg_start=1 -> LOAD, write index=0, cfg_err cleared.
REQ-017 LOAD: cfg_ready=1; handshake = cfg_valid & cfg_ready; each handshake writes cfg_data to shadow[index], index+1.
REQ-018 LOAD: a handshake at index=NTAP-1 -> ARMED; index does not wrap past NTAP-1.
REQ-019 LOAD: cfg_start=1 restarts the load (index=0, shadow content kept), and the same-cycle handshake is discarded.
REQ-020 ARMED: cfg_ready=0; sample_en=1 -> copy all NTAP shadow words to the active bank in one edge, then -> IDLE.
REQ-021 Active bank is registered; new values appear on coef the cycle after the ARMED & sample_en edge, and swap_done=1 that same cycle only.
REQ-022 coef changes only on a swap, never mid-sample; all NTAP words change together.
REQ-023 sample_en in IDLE or LOAD: no effect on coef.
REQ-024 sample_en in the same cycle as the final LOAD handshake: no swap; the swap waits for the next sample_en in ARMED.
REQ-025 cfg_start in ARMED: ignored for state, sets cfg_err=1.
REQ-026 cfg_valid=1 in IDLE or ARMED: word dropped, sets cfg_err=1.
REQ-027 cfg_err stays set until reset or the next accepted cfg_start in IDLE.
REQ-028 No arithmetic on data; words pass bit-exact, sign preserved.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, index=0, cfg_ready=0, busy=0, swap_done=0, cfg_err=0.
REQ-030 On rst_n=0, asynchronously: coef[0]=UNITY, coef[1..NTAP-1]=0, shadow bank all 0.
REQ-031 Reset asserted in LOAD or ARMED aborts the load; the active bank takes its reset values and no swap_done is issued.
REQ-032 Normal operation resumes on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 Reset -> coef[0]=16'h7FFF, coef[1..15]=0, all outputs 0.
REQ-034 cfg_start, then 16 handshakes with data 1..16 (gaps in cfg_valid), then sample_en -> coef[i]=i+1 one cycle later, swap_done high exactly 1 cycle, busy low afterwards.
REQ-035 Load of 16'h8000 (-32768) and 16'hFFFF (-1) at taps 3 and 15 -> same bit patterns on coef[3] and coef[15].
REQ-036 Final handshake and sample_en in the same cycle -> coef unchanged; swap occurs on the next sample_en.
REQ-037 cfg_start after 7 words, then 16 words of 16'h0055 -> every tap = 16'h0055, no leftover from the first 7 words.
REQ-038 cfg_start in ARMED and cfg_valid in IDLE -> cfg_err=1 held; the swap still completes; the next cfg_start clears cfg_err. Reset asserted after 10 words -> coef returns to the reset values.
